// File: rtl/avg_pkg.sv
// rtl/avg_pkg.sv - shared types and helpers for the port averager
package avg_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DIVIDE, DONE} avg_state_t;

  function automatic int avg_clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/avg_restoring_divider.sv
// rtl/avg_restoring_divider.sv - iterative restoring divider, one quotient bit per cycle
module avg_restoring_divider
  import avg_pkg::*;
#(
  parameter int ACC_W = 12,
  parameter int CNT_W = 4,
  parameter int Q_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [ACC_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [Q_W-1:0]   quotient,
  output logic             valid
);

  localparam int ITER_W = avg_clog2(ACC_W + 1);

  logic [ACC_W-1:0]  quo_r;
  logic [CNT_W-1:0]  rem_r;
  logic [CNT_W-1:0]  dsr_r;
  logic [ITER_W-1:0] iter_r;

  logic [CNT_W:0]    trial;
  logic [CNT_W:0]    diff;
  logic              ge;
  logic [CNT_W-1:0]  rem_next;
  logic [ACC_W-1:0]  quo_next;

  // The remainder never reaches the divisor, so CNT_W bits hold it and the
  // shifted trial value fits in CNT_W+1 bits.
  always_comb begin
    trial    = {rem_r, quo_r[ACC_W-1]};
    diff     = trial - {1'b0, dsr_r};
    ge       = (trial >= {1'b0, dsr_r});
    rem_next = ge ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
    quo_next = {quo_r[ACC_W-2:0], ge};
  end

  // quotient/valid describe the bit being retired this cycle, so the final
  // result is available in the same cycle as the last iteration.
  assign quotient = quo_next[Q_W-1:0];
  assign valid    = (iter_r == ITER_W'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      quo_r  <= '0;
      rem_r  <= '0;
      dsr_r  <= '0;
      iter_r <= '0;
    end else if (load) begin
      quo_r  <= dividend;
      rem_r  <= '0;
      dsr_r  <= divisor;
      iter_r <= ITER_W'(ACC_W);
    end else if (iter_r != '0) begin
      quo_r  <= quo_next;
      rem_r  <= rem_next;
      iter_r <= iter_r - ITER_W'(1);
    end
  end

endmodule

// File: rtl/port_averager.sv
// rtl/port_averager.sv - strobe-fed sample accumulator with sequential mean calculation
module port_averager
  import avg_pkg::*;
#(
  parameter int  DATA_W    = 8,
  parameter int  N_SAMPLES = 10,
  parameter int  AUTO      = 0,
  parameter int  ROUND     = 0,
  localparam int CNT_W     = avg_clog2(N_SAMPLES + 1),
  localparam int ACC_W     = DATA_W + CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_strb,
  input  logic              start,
  input  logic              clear,
  output logic [DATA_W-1:0] avg_out,
  output logic              done,
  output logic              busy,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              div_zero
);

  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_SAMPLES);

  avg_state_t        state;
  logic [ACC_W-1:0]  acc;
  logic              strb_cur, strb_prev;
  logic              start_cur, start_prev;

  logic              strb_edge, start_edge;
  logic              accept;
  logic [ACC_W-1:0]  sample_ext;
  logic [ACC_W-1:0]  acc_add;
  logic [CNT_W-1:0]  count_add;
  logic [CNT_W-1:0]  count_after;
  logic [ACC_W-1:0]  round_add;
  logic              div_load;
  logic [ACC_W-1:0]  div_dividend;
  logic [DATA_W-1:0] div_q;
  logic              div_valid;

  always_comb begin
    strb_edge    = strb_cur & ~strb_prev;
    start_edge   = start_cur & ~start_prev;
    accept       = strb_edge && (count < N_CNT);
    sample_ext   = {{CNT_W{1'b0}}, sample_in};
    acc_add      = acc + sample_ext;
    count_add    = count + CNT_W'(1);
    // Window occupancy after this cycle's sample, used for auto-start.
    count_after  = clear ? '0 : (accept ? count_add : count);
    round_add    = (ROUND != 0) ? {{DATA_W{1'b0}}, (count >> 1)} : '0;
    div_load     = (state == LOAD) && (count != '0);
    div_dividend = acc + round_add;
  end

  avg_restoring_divider #(
    .ACC_W(ACC_W),
    .CNT_W(CNT_W),
    .Q_W  (DATA_W)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .load    (div_load),
    .dividend(div_dividend),
    .divisor (count),
    .quotient(div_q),
    .valid   (div_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      acc        <= '0;
      count      <= '0;
      avg_out    <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      div_zero   <= 1'b0;
      strb_cur   <= 1'b0;
      strb_prev  <= 1'b0;
      start_cur  <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      strb_cur   <= sample_strb;
      strb_prev  <= strb_cur;
      start_cur  <= start;
      start_prev <= start_cur;
      done       <= 1'b0;

      // Window update; LOAD hands the old window to the divider and reopens
      // an empty one that may already take this cycle's sample.
      if (clear) begin
        acc      <= '0;
        count    <= '0;
        overflow <= 1'b0;
        div_zero <= 1'b0;
      end else if (state == LOAD) begin
        acc   <= strb_edge ? sample_ext : '0;
        count <= strb_edge ? CNT_W'(1) : '0;
      end else if (accept) begin
        acc   <= acc_add;
        count <= count_add;
      end else if (strb_edge) begin
        overflow <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start_edge || ((AUTO != 0) && (count_after == N_CNT))) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (count == '0) begin
            state   <= DONE;
            avg_out <= '0;
            done    <= 1'b1;
            if (!clear) div_zero <= 1'b1;
          end else begin
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (div_valid) begin
            state   <= DONE;
            avg_out <= div_q;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
